seg7_scan_reader: RTL and testbench

//  Reads a time-multiplexed, active-low 7-segment display bus (anodes + segments) and

---
 rtl/seg7_scan_reader.sv | 96 +++++++++
 tb/tb_seg7_scan_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers BCD digits from a multiplexed active-low 7-segment bus
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  sample_valid,
  output logic [IW-1:0]         sample_idx,
  output logic                  frame_valid,
  output logic                  frame_err
);
  typedef enum logic [1:0] {IDLE, COUNT, CAPTURED} state_t;
  state_t state;
  logic [DIGITS-1:0] an_r, mask, mask_nxt, err_nxt;
  logic [6:0] seg_r;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [3:0] dec;
  logic qual, chg, cap, err;
  // dwell qualification, active position, segment decode and next frame bookkeeping
  always_comb begin
    qual = ($countones(~an_r) == 1) && (seg_r != 7'h7F);
    chg = {an_n, seg} != {an_r, seg_r};
    cap = (state == COUNT) && !chg && (cnt == CW'(STABLE_CYCLES - 1));
    idx = '0;
    for (int i = 0; i < DIGITS; i++) if (!an_r[i]) idx = IW'(i);
    case (seg_r)
      7'b0000001: dec = 4'd0;
      7'b1001111: dec = 4'd1;
      7'b0010010: dec = 4'd2;
      7'b0000110: dec = 4'd3;
      7'b1001100: dec = 4'd4;
      7'b0100100: dec = 4'd5;
      7'b0100000: dec = 4'd6;
      7'b0001111: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0000100: dec = 4'd9;
      default:    dec = 4'hF;
    endcase
    err = dec == 4'hF;
    err_nxt = digit_err;
    err_nxt[idx] = err;
    mask_nxt = mask | (DIGITS'(1) << idx);
  end
  // input capture, dwell FSM and registered capture/frame outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r <= '1;
      seg_r <= '1;
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      bcd_out <= '0;
      digit_err <= '0;
      sample_valid <= 1'b0;
      sample_idx <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      an_r <= an_n;
      seg_r <= seg;
      sample_valid <= 1'b0;
      frame_valid <= 1'b0;
      if (chg) begin
        cnt <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (qual) begin
            state <= COUNT;
            cnt <= CW'(1);
          end
          COUNT: cnt <= cnt + 1'b1;
          default: ;
        endcase
      end
      if (cap) begin
        state <= CAPTURED;
        bcd_out[4*idx +: 4] <= dec;
        digit_err <= err_nxt;
        sample_valid <= 1'b1;
        sample_idx <= idx;
        mask <= &mask_nxt ? '0 : mask_nxt;
        frame_valid <= &mask_nxt;
        if (&mask_nxt) frame_err <= |err_nxt;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: random and directed dwells checked against a dwell-level model
module tb_seg7_scan_reader;
  localparam int S = 4;
  logic clk = 0, rst = 1;
  logic [3:0] an_n = '1;
  logic [6:0] seg = '1;
  logic [15:0] bcd_out;
  logic [3:0] digit_err;
  logic sample_valid, frame_valid, frame_err;
  logic [1:0] sample_idx;
  int total = 0, bad = 0;
  logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [3:0] exp_bcd [4];
  logic [3:0] exp_err, exp_mask;
  logic [3:0] prev_a = '1;
  logic [6:0] prev_s = '1;

  seg7_scan_reader #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .seg(seg), .bcd_out(bcd_out), .digit_err(digit_err),
    .sample_valid(sample_valid), .sample_idx(sample_idx), .frame_valid(frame_valid),
    .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] packed_bcd();
    return {exp_bcd[3], exp_bcd[2], exp_bcd[1], exp_bcd[0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    an_n = '1; seg = '1; rst = 1;
    prev_a = '1; prev_s = '1;
    @(posedge clk); #1;
    chk("rst_bcd", bcd_out, 16'h0);
    chk("rst_err", {12'h0, digit_err}, 16'h0);
    chk("rst_sv", {15'h0, sample_valid}, 16'h0);
    chk("rst_idx", {14'h0, sample_idx}, 16'h0);
    chk("rst_fv", {15'h0, frame_valid}, 16'h0);
    chk("rst_fe", {15'h0, frame_err}, 16'h0);
    for (int i = 0; i < 4; i++) exp_bcd[i] = 0;
    exp_err = 0; exp_mask = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    bit q, fire, fv, fe;
    int p;
    logic [3:0] d;
    @(negedge clk);
    an_n = a; seg = s;
    prev_a = a; prev_s = s;
    q = ($countones(~a) == 1) && (s != 7'h7F);
    p = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) p = i;
    d = 4'hF;
    for (int j = 0; j < 10; j++) if (pats[j] == s) d = 4'(j);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      fire = q && (k == S + 1);
      fv = 0; fe = 0;
      if (fire) begin
        exp_bcd[p] = d;
        exp_err[p] = (d == 4'hF);
        exp_mask[p] = 1;
        if (&exp_mask) begin
          fv = 1; fe = |exp_err; exp_mask = 0;
        end
      end
      chk("sample_valid", {15'h0, sample_valid}, {15'h0, fire});
      chk("frame_valid", {15'h0, frame_valid}, {15'h0, fv});
      chk("bcd_out", bcd_out, packed_bcd());
      chk("digit_err", {12'h0, digit_err}, {12'h0, exp_err});
      if (fire) chk("sample_idx", {14'h0, sample_idx}, 16'(p));
      if (fv) chk("frame_err", {15'h0, frame_err}, {15'h0, fe});
    end
  endtask

  task automatic scan(input int d0, input int d1, input logic [6:0] s2, input int d3, input int len);
    dwell(4'b1110, pats[d0], len);
    dwell(4'b1101, pats[d1], len);
    dwell(4'b1011, s2, len);
    dwell(4'b0111, pats[d3], len);
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r;
    do_reset();
    dwell(4'b1110, pats[2], 10);
    chk("t1_bcd", bcd_out, 16'h0002);
    scan(1, 9, pats[0], 7, 8);
    chk("t2_bcd", bcd_out, 16'h7091);
    scan(1, 9, 7'b0110000, 7, 8);
    chk("t3_bcd", bcd_out[11:8], 16'hF);
    chk("t3_err", {12'h0, digit_err}, 16'h0004);
    chk("t3_fe", {15'h0, frame_err}, 16'h1);
    scan(3, 4, pats[5], 6, 8);
    chk("t3b_err", {12'h0, digit_err}, 16'h0);
    chk("t3b_fe", {15'h0, frame_err}, 16'h0);
    for (int i = 0; i < 8; i++) dwell(~(4'b1 << (i % 4)), pats[i], 3);
    dwell(4'b1100, pats[8], 10);
    dwell(4'b1110, 7'h7F, 10);
    dwell(4'b1110, pats[3], 2);
    dwell(4'b1110, pats[5], 1);
    dwell(4'b1110, pats[3], 6);
    dwell(4'b1101, pats[6], 6);
    do_reset();
    scan(8, 7, pats[6], 5, 6);
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      a = r < 7 ? ~(4'b1 << $urandom_range(0, 3)) : r == 7 ? 4'hF : r == 8 ? 4'($urandom) : 4'b1010;
      r = $urandom_range(0, 9);
      s = r < 8 ? pats[$urandom_range(0, 9)] : r == 8 ? 7'($urandom) : 7'h7F;
      if ({a, s} == {prev_a, prev_s}) s = s ^ 7'h40;
      dwell(a, s, $urandom_range(1, 9));
      if (n == 120) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
